// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - launch/result bundle between the ALU sequencer and the bit-serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder/subtractor with start/busy/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    count;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    // One full-adder slice: the XOR primitive plus a majority carry.
    always_comb begin
        bit_s    = op_a[0] ^ op_b[0] ^ carry;
        bit_c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        res_next = {bit_s, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            count    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1: invert B here, seed the carry with SUB.
                        op_a     <= bus.a;
                        op_b     <= bus.b ^ {WIDTH{bus.sub}};
                        carry    <= bus.sub;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_next;
                    carry <= bit_c;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        // carry still holds the carry into the MSB on this last slice.
                        bus.sum  <= res_next;
                        bus.cout <= bit_c;
                        bus.ovf  <= carry ^ bit_c;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end
                end

                FIN: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op_a     <= bus.a;
                        op_b     <= bus.b ^ {WIDTH{bus.sub}};
                        carry    <= bus.sub;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed checks of serial_adder against a word-level model
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level result: {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sub);
        logic [WIDTH-1:0] bo;
        logic [WIDTH:0]   t;
        logic             v;
        bo = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bo} + {{WIDTH{1'b0}}, sub};
        v  = (a[WIDTH-1] == bo[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        return {v, t};
    endfunction

    // Timing model: an accepted launch completes WIDTH edges later.
    int               m_left = 0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf  = 1'b0;
    logic [WIDTH+1:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    {m_ovf, m_cout, m_sum} = m_pend;
                end
            end else if (bus.start) begin
                m_pend = ref_op(bus.a, bus.b, bus.sub);
                m_left = WIDTH;
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("sum",  32'(bus.sum),  32'(m_sum));
        chk("cout", 32'(bus.cout), 32'(m_cout));
        chk("ovf",  32'(bus.ovf),  32'(m_ovf));
    end

    task automatic wait_done(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n = i;
                found = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(found), 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                          input logic [WIDTH-1:0] e_sum, input logic e_cout, input logic e_ovf);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
        bus.sub = 1'($urandom);
        wait_done(n);
        chk("latency", 32'(n), 32'(WIDTH));
        chk("lit_sum", 32'(bus.sum), 32'(e_sum));
        chk("lit_cout", 32'(bus.cout), 32'(e_cout));
        chk("lit_ovf", 32'(bus.ovf), 32'(e_ovf));
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);

        // START already high when reset releases: accepted on the first edge.
        bus.start = 1'b1;
        bus.a = 8'h05;
        bus.b = 8'h03;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("first_busy", 32'(bus.busy), 32'd1);
        wait_done(n);
        chk("first_latency", 32'(n), 32'd8);
        chk("first_sum", 32'(bus.sum), 32'h08);

        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // START during RUN is ignored; START held in the DONE cycle chains a new op.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h05;
        bus.b = 8'h03;
        bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h11;
        bus.sub = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        chk("ignore_latency", 32'(n), 32'd5);
        chk("ignore_sum", 32'(bus.sum), 32'h08);
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h20;
        bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(n);
        chk("b2b_latency", 32'(n), 32'd8);
        chk("b2b_sum", 32'(bus.sum), 32'h30);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_sum", 32'(bus.sum), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Random traffic, including START noise mid-run and back-to-back launches.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
            bus.sub = 1'($urandom);
            if (i == 400) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
